// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - shared TAP state encoding for the TAP controller, IR and DR chains
package tap_pkg;

  localparam int TAP_STATE_W = 4;

  typedef enum logic [TAP_STATE_W-1:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SEL_DR  = 4'h7,
    CAP_DR  = 4'h6,
    SH_DR   = 4'h2,
    EX1_DR  = 4'h1,
    PAU_DR  = 4'h3,
    EX2_DR  = 4'h0,
    UPD_DR  = 4'h5,
    SEL_IR  = 4'h4,
    CAP_IR  = 4'hE,
    SH_IR   = 4'hA,
    EX1_IR  = 4'h9,
    PAU_IR  = 4'hB,
    EX2_IR  = 4'h8,
    UPD_IR  = 4'hD
  } tap_state_t;

endpackage

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - IEEE 1149.1 TAP state machine with strobe decode and tdo mux
module tap_controller
  import tap_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  input  logic       tdo_ir,
  input  logic       tdo_dr,
  output logic       tl_reset,
  output logic       captureIR,
  output logic       shiftIR,
  output logic       updateIR,
  output logic       captureDR,
  output logic       shiftDR,
  output logic       updateDR,
  output logic       ir_clk_en,
  output logic       dr_clk_en,
  output logic       select,
  output logic       tdo,
  output logic       tdo_en,
  output logic [3:0] state
);

  tap_state_t state_q, state_d;

  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // reset wins over tms so an in-flight shift can never reach an Update state
  always_ff @(posedge tck) begin
    if (reset) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    tl_reset  = (state_q != TLR);
    captureIR = (state_q == CAP_IR);
    shiftIR   = (state_q == SH_IR);
    updateIR  = (state_q == UPD_IR);
    captureDR = (state_q == CAP_DR);
    shiftDR   = (state_q == SH_DR);
    updateDR  = (state_q == UPD_DR);
    select    = 1'b0;
    case (state_q)
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR: select = 1'b1;
      default: select = 1'b0;
    endcase
    ir_clk_en = captureIR | shiftIR;
    dr_clk_en = captureDR | shiftDR;
    tdo_en    = shiftIR | shiftDR;
    tdo       = shiftIR ? tdo_ir : (shiftDR ? tdo_dr : 1'b1);
    state     = state_q;
  end

  a_state_known: assert property (@(posedge tck) disable iff (reset) !$isunknown(state_q));

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - randomized self-checking bench for tap_controller
module tb_tap_controller;

  logic       tck = 1'b0;
  logic       reset, tms, tdo_ir, tdo_dr;
  logic       tl_reset, captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR;
  logic       ir_clk_en, dr_clk_en, select, tdo, tdo_en;
  logic [3:0] state;

  tap_controller dut (
    .tck(tck), .reset(reset), .tms(tms), .tdo_ir(tdo_ir), .tdo_dr(tdo_dr),
    .tl_reset(tl_reset), .captureIR(captureIR), .shiftIR(shiftIR), .updateIR(updateIR),
    .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
    .ir_clk_en(ir_clk_en), .dr_clk_en(dr_clk_en), .select(select),
    .tdo(tdo), .tdo_en(tdo_en), .state(state)
  );

  always #5 tck = ~tck;

  // Reference model: a phase within the TAP diagram plus which branch (IR/DR) we are in.
  typedef enum int {P_TLR, P_RTI, P_SEL, P_CAP, P_SH, P_EX1, P_PAU, P_EX2, P_UPD} phase_t;
  phase_t m_ph = P_TLR;
  bit     m_ir = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_code();
    logic [3:0] dr_codes [9];
    logic [3:0] ir_codes [9];
    dr_codes = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5};
    ir_codes = '{4'hF, 4'hC, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    return m_ir ? ir_codes[int'(m_ph)] : dr_codes[int'(m_ph)];
  endfunction

  task automatic model_edge(input bit t, input bit r);
    if (r) begin
      m_ph = P_TLR; m_ir = 1'b0;
    end else begin
      case (m_ph)
        P_TLR: if (!t) m_ph = P_RTI;
        P_RTI: if (t) begin m_ph = P_SEL; m_ir = 1'b0; end
        P_SEL: if (!t) m_ph = P_CAP;
               else if (!m_ir) m_ir = 1'b1;
               else begin m_ph = P_TLR; m_ir = 1'b0; end
        P_CAP, P_SH: m_ph = t ? P_EX1 : P_SH;
        P_EX1: m_ph = t ? P_UPD : P_PAU;
        P_PAU: m_ph = t ? P_EX2 : P_PAU;
        P_EX2: m_ph = t ? P_UPD : P_SH;
        P_UPD: begin m_ph = t ? P_SEL : P_RTI; m_ir = 1'b0; end
        default: m_ph = P_TLR;
      endcase
    end
  endtask

  function automatic logic [10:0] m_outs();
    bit cap = (m_ph == P_CAP), sh = (m_ph == P_SH), upd = (m_ph == P_UPD);
    bit in_branch = (m_ph >= P_SEL);
    return {m_ph != P_TLR, cap & m_ir, sh & m_ir, upd & m_ir, cap & !m_ir, sh & !m_ir,
            upd & !m_ir, (cap | sh) & m_ir, (cap | sh) & !m_ir, in_branch & m_ir, sh};
  endfunction

  function automatic logic m_tdo();
    if (m_ph != P_SH) return 1'b1;
    return m_ir ? tdo_ir : tdo_dr;
  endfunction

  task automatic check_all(input string tag);
    chk_eq({tag, "_state"}, 32'(state), 32'(m_code()));
    chk_eq({tag, "_outs"}, 32'({tl_reset, captureIR, shiftIR, updateIR, captureDR, shiftDR,
                                updateDR, ir_clk_en, dr_clk_en, select, tdo_en}), 32'(m_outs()));
    chk_eq({tag, "_tdo"}, 32'(tdo), 32'(m_tdo()));
    tdo_ir = ~tdo_ir;
    tdo_dr = ~tdo_dr;
    #1;
    chk_eq({tag, "_tdo_flip"}, 32'(tdo), 32'(m_tdo()));
  endtask

  task automatic step(input bit t, input bit r, input string tag);
    tms    = t;
    reset  = r;
    tdo_ir = 1'($urandom);
    tdo_dr = 1'($urandom);
    @(posedge tck);
    model_edge(t, r);
    #1;
    check_all(tag);
  endtask

  task automatic step_exp(input bit t, input bit r, input logic [3:0] code, input string tag);
    step(t, r, tag);
    chk_eq({tag, "_code"}, 32'(state), 32'(code));
  endtask

  initial begin
    reset = 1'b1; tms = 1'b0; tdo_ir = 1'b0; tdo_dr = 1'b0;

    step_exp(0, 1, 4'hF, "t1_a");
    step_exp(0, 1, 4'hF, "t1_b");
    chk_eq("t1_tlreset", 32'(tl_reset), 32'd0);

    step_exp(0, 0, 4'hC, "t2_rti");
    step_exp(1, 0, 4'h7, "t2_seldr");
    step_exp(1, 0, 4'h4, "t2_selir");
    step_exp(0, 0, 4'hE, "t2_capir");
    chk_eq("t2_capir_strobe", 32'(captureIR), 32'd1);
    step_exp(0, 0, 4'hA, "t2_shir");
    chk_eq("t2_shir_en", 32'({shiftIR, ir_clk_en, tdo_en, captureIR}), 32'b1110);

    step_exp(1, 0, 4'h9, "t3_ex1ir");
    step_exp(1, 0, 4'hD, "t3_updir");
    chk_eq("t3_updir_strobe", 32'({updateIR, select}), 32'b11);
    step_exp(0, 0, 4'hC, "t3_rti");
    chk_eq("t3_select_drop", 32'({updateIR, select}), 32'b00);

    begin
      bit         seq_t [11];
      logic [3:0] seq_s [11];
      seq_t = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0};
      seq_s = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5, 4'hC};
      for (int i = 0; i < 11; i++) step_exp(seq_t[i], 0, seq_s[i], $sformatf("t4_%0d", i));
    end

    step_exp(1, 0, 4'h7, "t5_seldr");
    step_exp(0, 0, 4'h6, "t5_capdr");
    step_exp(0, 0, 4'h2, "t5_shdr");
    step_exp(1, 0, 4'h1, "t5_e1");
    step_exp(1, 0, 4'h5, "t5_e2");
    step_exp(1, 0, 4'h7, "t5_e3");
    step_exp(1, 0, 4'h4, "t5_e4");
    chk_eq("t5_tlreset_pre", 32'(tl_reset), 32'd1);
    step_exp(1, 0, 4'hF, "t5_e5");
    chk_eq("t5_tlreset_post", 32'(tl_reset), 32'd0);

    step_exp(0, 0, 4'hC, "t6_rti");
    step_exp(1, 0, 4'h7, "t6_seldr");
    step_exp(1, 0, 4'h4, "t6_selir");
    step_exp(0, 0, 4'hE, "t6_capir");
    step_exp(0, 0, 4'hA, "t6_shir");
    step_exp(0, 1, 4'hF, "t6_reset");
    chk_eq("t6_shift_drop", 32'({shiftIR, updateIR, tdo_en}), 32'b000);
    step_exp(0, 0, 4'hC, "t6_after");

    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) begin
        for (int k = 0; k < 5; k++) step(1, 0, $sformatf("r5_%0d_%0d", i, k));
        chk_eq($sformatf("r5_tlr_%0d", i), 32'(state), 32'hF);
      end else begin
        step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3, $sformatf("rnd_%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
